// File: rtl/oserdes_word_tx.sv
// Word-to-serial transmitter: buffers one parallel word and shifts it out LSB-first, one bit per CLK0.
// Idle word slots carry the training pattern; IOCE marks the first bit of every slot.
module oserdes_word_tx #(
  parameter int          DATA_WIDTH    = 4,
  parameter logic [7:0]  TRAIN_PATTERN = 8'h0A,
  parameter string       IDLE_MODE     = "TRAIN"
) (
  input  logic                  CLK0,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  DVALID,
  output logic                  DREADY,
  output logic                  OQ,
  output logic                  TQ,
  output logic                  IOCE,
  output logic                  UNDERRUN
);

  localparam int                    CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST     = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] TRAIN    = TRAIN_PATTERN[DATA_WIDTH-1:0];
  localparam bit                    TRISTATE = (IDLE_MODE == "TRISTATE");

  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] hold;
  logic [CW-1:0]         cnt;
  logic                  hold_full;
  logic                  is_data;
  logic                  underrun_q;
  logic                  accept;
  logic                  load_edge;

  assign DREADY    = !hold_full && !RST;
  assign accept    = DVALID && DREADY;
  assign load_edge = (cnt == LAST);

  assign OQ       = sr[0];
  assign IOCE     = (cnt == '0);
  assign TQ       = TRISTATE && !is_data;
  assign UNDERRUN = underrun_q;

  // NOTE: all state uses non-blocking assignments so every branch below reads
  // the pre-edge values, which is what makes accept-and-load on one edge safe.
  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      sr         <= TRAIN;
      hold       <= '0;
      cnt        <= '0;
      hold_full  <= 1'b0;
      is_data    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      // Accept is only possible with hold empty, so it never collides with a hold-consuming load.
      if (accept) begin
        hold      <= D;
        hold_full <= 1'b1;
      end

      if (load_edge) begin
        cnt <= '0;
        if (hold_full) begin
          sr        <= hold;
          is_data   <= 1'b1;
          hold_full <= 1'b0;
        end else begin
          sr         <= TRAIN;
          is_data    <= 1'b0;
          underrun_q <= is_data;
        end
      end else begin
        sr  <= sr >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oserdes_word_tx.sv
// Directed bench for oserdes_word_tx: a TRAIN-mode and a TRISTATE-mode instance share one stimulus stream.
// Inputs change and outputs are sampled on the falling edge of CLK0.
module tb_oserdes_word_tx;

  localparam int         W  = 4;
  localparam logic [3:0] TP = 4'b1010;

  logic         CLK0 = 1'b0;
  logic         RST;
  logic         DVALID;
  logic [W-1:0] D;

  logic oq_a, tq_a, ioce_a, und_a, rdy_a;
  logic oq_b, tq_b, ioce_b, und_b, rdy_b;

  int total = 0;
  int bad   = 0;

  oserdes_word_tx #(.DATA_WIDTH(W), .TRAIN_PATTERN(8'h0A), .IDLE_MODE("TRAIN")) dut_train (
    .CLK0(CLK0), .RST(RST), .D(D), .DVALID(DVALID), .DREADY(rdy_a),
    .OQ(oq_a), .TQ(tq_a), .IOCE(ioce_a), .UNDERRUN(und_a)
  );

  oserdes_word_tx #(.DATA_WIDTH(W), .TRAIN_PATTERN(8'h0A), .IDLE_MODE("TRISTATE")) dut_tris (
    .CLK0(CLK0), .RST(RST), .D(D), .DVALID(DVALID), .DREADY(rdy_b),
    .OQ(oq_b), .TQ(tq_b), .IOCE(ioce_b), .UNDERRUN(und_b)
  );

  always #5 CLK0 = ~CLK0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one full word slot on both instances, advancing four cycles.
  task automatic check_slot(input string tag, input logic [3:0] w, input bit data, input bit und);
    for (int i = 0; i < W; i++) begin
      check({tag, "_oq"},     8'(oq_a),   8'(w[i]));
      check({tag, "_oq_b"},   8'(oq_b),   8'(w[i]));
      check({tag, "_ioce"},   8'(ioce_a), 8'(i == 0));
      check({tag, "_ioce_b"}, 8'(ioce_b), 8'(i == 0));
      check({tag, "_tq"},     8'(tq_a),   8'h00);
      check({tag, "_tq_b"},   8'(tq_b),   8'(!data));
      check({tag, "_und"},    8'(und_a),  8'(und && i == 0));
      check({tag, "_und_b"},  8'(und_b),  8'(und && i == 0));
      @(negedge CLK0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [5];
    seq[0] = TP; seq[1] = 4'h1; seq[2] = 4'h2; seq[3] = 4'h3; seq[4] = TP;

    RST = 1'b1; DVALID = 1'b0; D = '0;
    #12;
    check("rst_oq",    8'(oq_a),   8'h00);
    check("rst_ioce",  8'(ioce_a), 8'h01);
    check("rst_rdy",   8'(rdy_a),  8'h00);
    check("rst_tq",    8'(tq_a),   8'h00);
    check("rst_tq_b",  8'(tq_b),   8'h01);
    check("rst_und",   8'(und_a),  8'h00);

    @(negedge CLK0);
    RST = 1'b0;
    #1;
    check("rel_rdy", 8'(rdy_a), 8'h01);

    // Sixteen idle cycles of training pattern.
    repeat (4) check_slot("idle", TP, 1'b0, 1'b0);

    // Single word 4'hC accepted at cnt=0, loaded three edges later.
    D = 4'hC; DVALID = 1'b1;
    @(negedge CLK0);
    DVALID = 1'b0;
    check("c_rdy_held", 8'(rdy_a), 8'h00);
    @(negedge CLK0);
    @(negedge CLK0);
    check("c_rdy_cnt3", 8'(rdy_a), 8'h00);
    @(negedge CLK0);
    check("c_rdy_load", 8'(rdy_a), 8'h01);
    check_slot("word_c", 4'hC, 1'b1, 1'b0);
    check_slot("post_c", TP, 1'b0, 1'b1);

    // Back-to-back words 1,2,3 with DVALID held high.
    for (int t = 0; t < 20; t++) begin
      logic [3:0] w;
      w = seq[t / 4];
      check("b2b_oq",   8'(oq_a),  8'(w[t % 4]));
      check("b2b_ioce", 8'(ioce_a), 8'((t % 4) == 0));
      check("b2b_und",  8'(und_a), 8'(t == 16));
      check("b2b_tq_b", 8'(tq_b),  8'((t / 4) == 0 || (t / 4) == 4));
      check("b2b_rdy",  8'(rdy_a), 8'(((t % 4) == 0) || t > 12));
      if (t == 0)  begin D = 4'h1; DVALID = 1'b1; end
      if (t == 4)  D = 4'h2;
      if (t == 8)  D = 4'h3;
      if (t == 12) DVALID = 1'b0;
      @(negedge CLK0);
    end

    // Accept on the load edge: word skips the next slot, latency four cycles.
    repeat (3) @(negedge CLK0);
    check("late_cnt3_ioce", 8'(ioce_a), 8'h00);
    D = 4'h6; DVALID = 1'b1;
    @(negedge CLK0);
    DVALID = 1'b0;
    check("late_rdy", 8'(rdy_a), 8'h00);
    check_slot("skip", TP, 1'b0, 1'b0);
    check("late_rdy_load", 8'(rdy_a), 8'h01);
    check_slot("late", 4'h6, 1'b1, 1'b0);

    // Reset mid-word with a second word held.
    check("pre_rst_und", 8'(und_a), 8'h01);
    D = 4'hF; DVALID = 1'b1;
    @(negedge CLK0);
    DVALID = 1'b0;
    repeat (3) @(negedge CLK0);
    check("f_bit0", 8'(oq_a), 8'h01);
    D = 4'h5; DVALID = 1'b1;
    @(negedge CLK0);
    DVALID = 1'b0;
    check("f_bit1", 8'(oq_a), 8'h01);
    check("f_hold_rdy", 8'(rdy_a), 8'h00);
    @(negedge CLK0);
    check("f_bit2", 8'(oq_a), 8'h01);
    RST = 1'b1;
    #1;
    check("mid_rst_oq",   8'(oq_a),   8'h00);
    check("mid_rst_ioce", 8'(ioce_a), 8'h01);
    check("mid_rst_rdy",  8'(rdy_a),  8'h00);
    check("mid_rst_tq_b", 8'(tq_b),   8'h01);
    @(negedge CLK0);
    RST = 1'b0;
    #1;
    check("post_rst_rdy", 8'(rdy_a), 8'h01);
    check_slot("after_rst", TP, 1'b0, 1'b0);
    check_slot("after_rst2", TP, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
